// File: rtl/grid_walk_controller.sv
// Tile-locked player movement engine: turn in place, probe the target tile against
// an external collision lookup, then glide one tile at STEP_PX per frame tick.
module grid_walk_controller #(
    parameter int unsigned TILE_PX     = 16,
    parameter int unsigned STEP_PX     = 1,
    parameter int unsigned MAP_W       = 20,
    parameter int unsigned MAP_H       = 15,
    parameter int unsigned START_TX    = 10,
    parameter int unsigned START_TY    = 7,
    parameter int unsigned TURN_FRAMES = 4,
    parameter logic [7:0]  KC_UP       = 8'h1A,
    parameter logic [7:0]  KC_DOWN     = 8'h16,
    parameter logic [7:0]  KC_LEFT     = 8'h04,
    parameter logic [7:0]  KC_RIGHT    = 8'h07,
    localparam int unsigned TXW        = $clog2(MAP_W),
    localparam int unsigned TYW        = $clog2(MAP_H)
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           frame_sync,
    input  logic [7:0]     keycode,
    input  logic           blocked,
    output logic [TXW-1:0] target_tx,
    output logic [TYW-1:0] target_ty,
    output logic [TXW-1:0] tile_x,
    output logic [TYW-1:0] tile_y,
    output logic [9:0]     pix_x,
    output logic [9:0]     pix_y,
    output logic [1:0]     Direction,
    output logic           Character_Moving,
    output logic [1:0]     anim_phase
);

    localparam int unsigned OFFW = $clog2(TILE_PX) + 1;
    localparam int unsigned SH   = $clog2(TILE_PX);
    localparam int unsigned CNTW = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;

    localparam logic [OFFW-1:0] TILE_O = OFFW'(TILE_PX);
    localparam logic [OFFW-1:0] HALF_O = OFFW'(TILE_PX / 2);
    localparam logic [OFFW-1:0] STEP_O = OFFW'(STEP_PX);
    localparam logic [TXW-1:0]  MAX_TX = TXW'(MAP_W - 1);
    localparam logic [TYW-1:0]  MAX_TY = TYW'(MAP_H - 1);
    localparam logic [TXW-1:0]  RST_TX = TXW'(START_TX);
    localparam logic [TYW-1:0]  RST_TY = TYW'(START_TY);
    localparam logic [9:0]      RST_PX = 10'(START_TX * TILE_PX);
    localparam logic [9:0]      RST_PY = 10'(START_TY * TILE_PX);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {IDLE, TURN, CHECK, WALK} state_t;

    state_t          state_q, state_n;
    logic [1:0]      dir_q, dir_n;
    logic [CNTW-1:0] cnt_q, cnt_n;
    logic [TXW-1:0]  tile_x_q, tile_x_n;
    logic [TYW-1:0]  tile_y_q, tile_y_n;
    logic [OFFW-1:0] off_q, off_n;
    logic [9:0]      pix_x_q, pix_x_n;
    logic [9:0]      pix_y_q, pix_y_n;
    logic            moving_q, moving_n;
    logic [1:0]      anim_q, anim_n;

    logic [2:0]      sync_q;
    logic            tick_q;

    logic            key_vld;
    logic [1:0]      kdir;
    logic [TXW-1:0]  nb_x;
    logic [TYW-1:0]  nb_y;
    logic            oob;
    logic [OFFW-1:0] off_step;
    logic [9:0]      base_x, base_y;
    logic            half_x, done;

    // Two-flop synchroniser plus edge detect; tick is registered so it lands 3 clocks after the rise
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= 3'b000;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], frame_sync};
            tick_q <= sync_q[1] & ~sync_q[2];
        end
    end

    always_comb begin
        key_vld = 1'b1;
        kdir    = DIR_DOWN;
        if (keycode == KC_UP)         kdir = DIR_UP;
        else if (keycode == KC_DOWN)  kdir = DIR_DOWN;
        else if (keycode == KC_LEFT)  kdir = DIR_LEFT;
        else if (keycode == KC_RIGHT) kdir = DIR_RIGHT;
        else                          key_vld = 1'b0;
    end

    // Neighbouring tile along the facing direction, with map-edge detection
    always_comb begin
        nb_x = tile_x_q;
        nb_y = tile_y_q;
        oob  = 1'b0;
        case (dir_q)
            DIR_UP:    if (tile_y_q == '0)     oob = 1'b1; else nb_y = tile_y_q - TYW'(1);
            DIR_DOWN:  if (tile_y_q == MAX_TY) oob = 1'b1; else nb_y = tile_y_q + TYW'(1);
            DIR_LEFT:  if (tile_x_q == '0)     oob = 1'b1; else nb_x = tile_x_q - TXW'(1);
            default:   if (tile_x_q == MAX_TX) oob = 1'b1; else nb_x = tile_x_q + TXW'(1);
        endcase
    end

    assign target_tx = (state_q == CHECK) ? nb_x : tile_x_q;
    assign target_ty = (state_q == CHECK) ? nb_y : tile_y_q;

    assign base_x   = 10'(tile_x_q) << SH;
    assign base_y   = 10'(tile_y_q) << SH;
    assign off_step = off_q + STEP_O;
    assign half_x   = (off_q < HALF_O) && (off_step >= HALF_O);
    assign done     = (off_step >= TILE_O);

    always_comb begin
        state_n  = state_q;
        dir_n    = dir_q;
        cnt_n    = cnt_q;
        tile_x_n = tile_x_q;
        tile_y_n = tile_y_q;
        off_n    = off_q;
        pix_x_n  = pix_x_q;
        pix_y_n  = pix_y_q;
        anim_n   = anim_q;
        case (state_q)
            IDLE: begin
                if (tick_q && key_vld) begin
                    if (kdir != dir_q) begin
                        dir_n   = kdir;
                        cnt_n   = CNTW'(TURN_FRAMES - 1);
                        state_n = TURN;
                    end else begin
                        state_n = CHECK;
                    end
                end
            end
            TURN: begin
                if (tick_q) begin
                    if (cnt_q != '0)                        cnt_n   = cnt_q - CNTW'(1);
                    else if (key_vld && (kdir == dir_q))    state_n = CHECK;
                    else                                    state_n = IDLE;
                end
            end
            CHECK: begin
                off_n   = '0;
                state_n = (oob || blocked) ? IDLE : WALK;
            end
            default: begin
                if (tick_q) begin
                    off_n  = off_step;
                    anim_n = anim_q + 2'(half_x) + 2'(done);
                    case (dir_q)
                        DIR_UP:   pix_y_n = base_y - 10'(off_step);
                        DIR_DOWN: pix_y_n = base_y + 10'(off_step);
                        DIR_LEFT: pix_x_n = base_x - 10'(off_step);
                        default:  pix_x_n = base_x + 10'(off_step);
                    endcase
                    if (done) begin
                        // Snap onto the new tile; a held key chains straight into the next probe
                        tile_x_n = nb_x;
                        tile_y_n = nb_y;
                        off_n    = '0;
                        pix_x_n  = 10'(nb_x) << SH;
                        pix_y_n  = 10'(nb_y) << SH;
                        state_n  = (key_vld && (kdir == dir_q)) ? CHECK : IDLE;
                    end
                end
            end
        endcase
        if ((state_n == IDLE) && (state_q != IDLE)) anim_n = 2'd0;
        // A chained probe keeps the walk flag up so back-to-back tiles show no gap
        moving_n = (state_n == WALK) || ((state_n == CHECK) && (state_q == WALK));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            dir_q    <= DIR_DOWN;
            cnt_q    <= '0;
            tile_x_q <= RST_TX;
            tile_y_q <= RST_TY;
            off_q    <= '0;
            pix_x_q  <= RST_PX;
            pix_y_q  <= RST_PY;
            moving_q <= 1'b0;
            anim_q   <= 2'd0;
        end else begin
            state_q  <= state_n;
            dir_q    <= dir_n;
            cnt_q    <= cnt_n;
            tile_x_q <= tile_x_n;
            tile_y_q <= tile_y_n;
            off_q    <= off_n;
            pix_x_q  <= pix_x_n;
            pix_y_q  <= pix_y_n;
            moving_q <= moving_n;
            anim_q   <= anim_n;
        end
    end

    assign tile_x           = tile_x_q;
    assign tile_y           = tile_y_q;
    assign pix_x            = pix_x_q;
    assign pix_y            = pix_y_q;
    assign Direction        = dir_q;
    assign Character_Moving = moving_q;
    assign anim_phase       = anim_q;

endmodule

// File: tb/tb_grid_walk_controller.sv
// Directed bench for grid_walk_controller: default map, a corner-start instance and a fast-step instance.
module tb_grid_walk_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fs = 1'b0;
    logic [7:0] key_m = 8'h00, key_e = 8'h00, key_f = 8'h00;
    logic blk_tile_en = 1'b0, blk_e = 1'b0;
    logic blk_m;

    logic [4:0] m_ttx, m_tx, e_ttx, e_tx, f_ttx, f_tx;
    logic [3:0] m_tty, m_ty, e_tty, e_ty, f_tty, f_ty;
    logic [9:0] m_px, m_py, e_px, e_py, f_px, f_py;
    logic [1:0] m_dir, e_dir, f_dir, m_an, e_an, f_an;
    logic       m_mv, e_mv, f_mv;

    int n_checks = 0;
    int n_errors = 0;
    int probe_hits = 0;

    localparam logic [7:0] K_W = 8'h1A, K_S = 8'h16, K_A = 8'h04, K_D = 8'h07;

    always #5 clk = ~clk;

    // Collision map for the main instance: only tile (14,7) is solid when enabled
    assign blk_m = blk_tile_en && (m_ttx == 5'd14) && (m_tty == 4'd7);

    always @(posedge clk) if (blk_m) probe_hits <= probe_hits + 1;

    grid_walk_controller u_main (
        .Clk(clk), .Reset_n(rst_n), .frame_sync(fs), .keycode(key_m), .blocked(blk_m),
        .target_tx(m_ttx), .target_ty(m_tty), .tile_x(m_tx), .tile_y(m_ty),
        .pix_x(m_px), .pix_y(m_py), .Direction(m_dir), .Character_Moving(m_mv), .anim_phase(m_an));

    grid_walk_controller #(.START_TX(0), .START_TY(0)) u_edge (
        .Clk(clk), .Reset_n(rst_n), .frame_sync(fs), .keycode(key_e), .blocked(blk_e),
        .target_tx(e_ttx), .target_ty(e_tty), .tile_x(e_tx), .tile_y(e_ty),
        .pix_x(e_px), .pix_y(e_py), .Direction(e_dir), .Character_Moving(e_mv), .anim_phase(e_an));

    grid_walk_controller #(.TURN_FRAMES(1), .STEP_PX(4)) u_fast (
        .Clk(clk), .Reset_n(rst_n), .frame_sync(fs), .keycode(key_f), .blocked(1'b0),
        .target_tx(f_ttx), .target_ty(f_tty), .tile_x(f_tx), .tile_y(f_ty),
        .pix_x(f_px), .pix_y(f_py), .Direction(f_dir), .Character_Moving(f_mv), .anim_phase(f_an));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One VGA frame: sync high then low; tick and any CHECK cycle complete inside it
    task automatic frame();
        @(negedge clk) fs = 1'b1;
        repeat (6) @(negedge clk);
        fs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tile_x", 32'(m_tx), 32'd10);
        check("rst_pix_y", 32'(m_py), 32'd112);
        check("rst_dir", 32'(m_dir), 32'd1);
        rst_n = 1'b1;

        // Idle frames with no key
        repeat (10) frame();
        check("idle_tile_x", 32'(m_tx), 32'd10);
        check("idle_tile_y", 32'(m_ty), 32'd7);
        check("idle_pix_x", 32'(m_px), 32'd160);
        check("idle_pix_y", 32'(m_py), 32'd112);
        check("idle_dir", 32'(m_dir), 32'd1);
        check("idle_moving", 32'(m_mv), 32'd0);
        check("idle_target", 32'(m_ttx), 32'd10);

        // Hold D: turn four ticks, then walk three chained tiles
        key_m = K_D;
        frame();
        check("turn_dir", 32'(m_dir), 32'd3);
        check("turn_moving", 32'(m_mv), 32'd0);
        repeat (3) frame();
        check("turn_end_moving", 32'(m_mv), 32'd0);
        check("turn_end_pix", 32'(m_px), 32'd160);
        frame();
        check("walk_start_moving", 32'(m_mv), 32'd1);
        check("walk_start_pix", 32'(m_px), 32'd160);
        for (int k = 1; k <= 48; k++) begin
            if (k == 48) key_m = 8'h00;
            frame();
            if (k < 48) begin
                check("walk_moving", 32'(m_mv), 32'd1);
                check("walk_pix_x", 32'(m_px), 32'(160 + k));
            end
            if (k == 8)  check("walk_anim_half", 32'(m_an), 32'd1);
            if (k == 16) begin
                check("tile1_x", 32'(m_tx), 32'd11);
                check("tile1_anim", 32'(m_an), 32'd2);
            end
            if (k == 32) check("tile2_x", 32'(m_tx), 32'd12);
        end
        check("walk_end_tile_x", 32'(m_tx), 32'd13);
        check("walk_end_tile_y", 32'(m_ty), 32'd7);
        check("walk_end_pix_x", 32'(m_px), 32'd208);
        check("walk_end_moving", 32'(m_mv), 32'd0);
        check("walk_end_anim", 32'(m_an), 32'd0);
        check("walk_end_dir", 32'(m_dir), 32'd3);

        // Solid tile at (14,7): probe refused, position kept
        blk_tile_en = 1'b1;
        key_m = K_D;
        repeat (3) frame();
        check("blk_tile_x", 32'(m_tx), 32'd13);
        check("blk_pix_x", 32'(m_px), 32'd208);
        check("blk_moving", 32'(m_mv), 32'd0);
        check("blk_probe_seen", 32'(probe_hits != 0), 32'd1);
        check("blk_target_idle", 32'(m_ttx), 32'd13);
        blk_tile_en = 1'b0;
        key_m = 8'h00;

        // Corner instance: map edges to the left and above
        key_e = K_A;
        for (int k = 0; k < 6; k++) begin
            frame();
            check("edge_left_moving", 32'(e_mv), 32'd0);
        end
        check("edge_left_dir", 32'(e_dir), 32'd2);
        check("edge_left_pix_x", 32'(e_px), 32'd0);
        check("edge_left_tile_x", 32'(e_tx), 32'd0);
        key_e = K_W;
        for (int k = 0; k < 6; k++) begin
            frame();
            check("edge_up_moving", 32'(e_mv), 32'd0);
        end
        check("edge_up_dir", 32'(e_dir), 32'd0);
        check("edge_up_pix_y", 32'(e_py), 32'd0);
        blk_e = 1'b1;
        key_e = K_S;
        for (int k = 0; k < 6; k++) begin
            frame();
            check("edge_blk_moving", 32'(e_mv), 32'd0);
        end
        check("edge_blk_dir", 32'(e_dir), 32'd1);
        check("edge_blk_tile_y", 32'(e_ty), 32'd0);
        key_e = K_D;
        repeat (6) frame();
        check("edge_blk_r_dir", 32'(e_dir), 32'd3);
        check("edge_blk_r_tile_x", 32'(e_tx), 32'd0);
        key_e = 8'h00;
        blk_e = 1'b0;

        // Fast instance: one-frame turn, 4 px steps
        key_f = K_W;
        frame();
        key_f = 8'h00;
        frame();
        check("fast_face_up", 32'(f_dir), 32'd0);
        key_f = K_S;
        frame();
        key_f = 8'h00;
        frame();
        check("fast_tap_dir", 32'(f_dir), 32'd1);
        check("fast_tap_tile_y", 32'(f_ty), 32'd7);
        check("fast_tap_moving", 32'(f_mv), 32'd0);
        key_f = K_S;
        frame();
        check("fast_walk_moving", 32'(f_mv), 32'd1);
        check("fast_walk_pix0", 32'(f_py), 32'd112);
        frame();
        check("fast_walk_pix1", 32'(f_py), 32'd116);
        frame();
        check("fast_walk_pix2", 32'(f_py), 32'd120);
        check("fast_walk_anim", 32'(f_an), 32'd1);
        frame();
        check("fast_walk_pix3", 32'(f_py), 32'd124);
        check("fast_walk_tile_y", 32'(f_ty), 32'd7);
        key_f = 8'h00;
        frame();
        check("fast_done_tile_y", 32'(f_ty), 32'd8);
        check("fast_done_pix_y", 32'(f_py), 32'd128);
        check("fast_done_moving", 32'(f_mv), 32'd0);

        // Async reset half-way through a step
        key_m = K_D;
        repeat (9) frame();
        check("mid_pix_x", 32'(m_px), 32'd216);
        check("mid_moving", 32'(m_mv), 32'd1);
        check("mid_anim", 32'(m_an), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tile_x", 32'(m_tx), 32'd10);
        check("arst_pix_x", 32'(m_px), 32'd160);
        check("arst_dir", 32'(m_dir), 32'd1);
        check("arst_moving", 32'(m_mv), 32'd0);
        check("arst_anim", 32'(m_an), 32'd0);
        check("arst_fast_tile_y", 32'(f_ty), 32'd7);
        key_m = 8'h00;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
